// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: rate-decoupling buffer between the IIR filter output and
// the PWM DAC. Both strobes are synchronized and edge-detected in the clk
// domain. A prefill state machine, hold-on-underflow and drop-on-overflow
// policies, and saturating error counters are included.
module audio_sample_fifo #(
  parameter int N          = 10,
  parameter int DEPTH_LOG2 = 3,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          sample_in,
  input  logic                  sample_valid,
  input  logic                  pwm_ready,
  output logic [N-1:0]          duty_out,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  running,
  output logic [CNT_W-1:0]      overflow_cnt,
  output logic [CNT_W-1:0]      underflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] HALF_L  = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic [N-1:0] DUTY_RST = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic {FILL, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [N-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;

  logic sv_s1, sv_s2, sv_d;
  logic pr_s1, pr_s2, pr_d;
  logic push, pop;
  logic push_acc, pop_take, overflow_evt, underflow_evt;

  assign push    = sv_s2 & ~sv_d;
  assign pop     = pr_s2 & ~pr_d;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign running = (state == RUN);

  // Synchronize both strobes and register the previous level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sv_s1 <= 1'b0;
      sv_s2 <= 1'b0;
      sv_d  <= 1'b0;
      pr_s1 <= 1'b0;
      pr_s2 <= 1'b0;
      pr_d  <= 1'b0;
    end else begin
      sv_s1 <= sample_valid;
      sv_s2 <= sv_s1;
      sv_d  <= sv_s2;
      pr_s1 <= pwm_ready;
      pr_s2 <= pr_s1;
      pr_d  <= pr_s2;
    end
  end

  // Decide which events take effect this cycle and the resulting occupancy/state.
  always_comb begin
    pop_take      = pop & running & ~empty;
    underflow_evt = pop & running & empty;
    // A pop at full frees a slot, so the simultaneous push still fits.
    push_acc      = push & (~full | pop_take);
    overflow_evt  = push & full & ~pop_take;
    level_next    = level;
    if (push_acc && !pop_take)
      level_next = level + 1'b1;
    else if (!push_acc && pop_take)
      level_next = level - 1'b1;
    state_next = state;
    case (state)
      FILL:    if (level_next >= HALF_L) state_next = RUN;
      RUN:     if (underflow_evt)        state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Sample storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= sample_in;
  end

  // Pointers, occupancy, state, output sample and saturating error counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FILL;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      duty_out      <= DUTY_RST;
      overflow_cnt  <= '0;
      underflow_cnt <= '0;
    end else begin
      state <= state_next;
      level <= level_next;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_take) begin
        duty_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (overflow_evt && overflow_cnt != '1)
        overflow_cnt <= overflow_cnt + 1'b1;
      if (underflow_evt && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

endmodule
